// File: rtl/ll_task_dispatcher_pkg.sv
// Shared types for the linked-list hash-table engines and the task dispatcher.
// Opcodes, result codes and the dispatcher's engine-ownership encoding.
package linked_list;

  localparam int LL_TABLE_ADDR_WIDTH = 8;

  typedef logic [2:0] ll_opcode_t;
  localparam ll_opcode_t LL_OP_NOP     = 3'd0;
  localparam ll_opcode_t LL_OP_ENQUEUE = 3'd1;
  localparam ll_opcode_t LL_OP_DEQUEUE = 3'd2;

  typedef logic [1:0] ll_rescode_t;
  localparam ll_rescode_t LL_OK             = 2'd0;
  localparam ll_rescode_t LL_EMPTY          = 2'd1;
  localparam ll_rescode_t LL_FULL           = 2'd2;
  localparam ll_rescode_t LL_UNKNOWN_OPCODE = 2'd3;

  typedef logic [1:0] ll_chain_state_t;
  localparam ll_chain_state_t LL_NO_CHAIN  = 2'd0;
  localparam ll_chain_state_t LL_IN_HEAD   = 2'd1;
  localparam ll_chain_state_t LL_IN_MIDDLE = 2'd2;
  localparam ll_chain_state_t LL_IN_TAIL   = 2'd3;

  typedef struct packed {
    ll_opcode_t  opcode;
    logic [7:0]  key;
    logic [15:0] value;
  } ll_cmd_t;

  typedef struct packed {
    ll_cmd_t                        cmd;
    logic [LL_TABLE_ADDR_WIDTH-1:0] head_ptr;
  } ll_ht_pdata_t;

  typedef struct packed {
    ll_cmd_t         cmd;
    ll_rescode_t     rescode;
    ll_chain_state_t chain_state;
  } ll_ht_result_t;

  typedef struct packed {
    logic [7:0]                     key;
    logic [15:0]                    value;
    logic [LL_TABLE_ADDR_WIDTH-1:0] next_ptr;
  } ll_ram_data_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_ENQ  = 2'd1,
    OWNER_DEQ  = 2'd2
  } ll_disp_owner_t;

  function automatic ll_disp_owner_t owner_of(input ll_opcode_t op);
    case (op)
      LL_OP_ENQUEUE: return OWNER_ENQ;
      LL_OP_DEQUEUE: return OWNER_DEQ;
      default:       return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ll_task_dispatcher_ram_port_mux.sv
// Combinational owner-select of the two engines' RAM requests onto the shared port.
// Flags any enable raised by the engine that does not currently own the RAM.
module ll_ram_port_mux
  import linked_list::*;
#(
  parameter int A_WIDTH = LL_TABLE_ADDR_WIDTH
) (
  input  ll_disp_owner_t     owner,
  input  logic [A_WIDTH-1:0] enq_rd_addr,
  input  logic               enq_rd_en,
  input  logic [A_WIDTH-1:0] enq_wr_addr,
  input  ll_ram_data_t       enq_wr_data,
  input  logic               enq_wr_en,
  input  logic [A_WIDTH-1:0] deq_rd_addr,
  input  logic               deq_rd_en,
  input  logic [A_WIDTH-1:0] deq_wr_addr,
  input  ll_ram_data_t       deq_wr_data,
  input  logic               deq_wr_en,
  output logic [A_WIDTH-1:0] ram_rd_addr,
  output logic               ram_rd_en,
  output logic [A_WIDTH-1:0] ram_wr_addr,
  output ll_ram_data_t       ram_wr_data,
  output logic               ram_wr_en,
  output logic               violation
);

  always_comb begin
    ram_rd_addr = '0;
    ram_rd_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    ram_wr_en   = 1'b0;
    case (owner)
      OWNER_ENQ: begin
        ram_rd_addr = enq_rd_addr;
        ram_rd_en   = enq_rd_en;
        ram_wr_addr = enq_wr_addr;
        ram_wr_data = enq_wr_data;
        ram_wr_en   = enq_wr_en;
      end
      OWNER_DEQ: begin
        ram_rd_addr = deq_rd_addr;
        ram_rd_en   = deq_rd_en;
        ram_wr_addr = deq_wr_addr;
        ram_wr_data = deq_wr_data;
        ram_wr_en   = deq_wr_en;
      end
      default: ;
    endcase
  end

  assign violation = ((enq_rd_en | enq_wr_en) & (owner != OWNER_ENQ)) |
                     ((deq_rd_en | deq_wr_en) & (owner != OWNER_DEQ));

endmodule

// File: rtl/ll_task_dispatcher.sv
// Routes one task at a time to the enqueue or dequeue engine; dispatch valid one cycle after accept.
// Upstream ready only in IDLE; holds dispatch and result until the far side is ready.
module ll_task_dispatcher
  import linked_list::*;
#(
  parameter int A_WIDTH   = LL_TABLE_ADDR_WIDTH,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  ll_ht_pdata_t         task_i,
  input  logic                 task_valid_i,
  output logic                 task_ready_o,
  output ll_ht_pdata_t         enq_task_o,
  output logic                 enq_task_valid_o,
  input  logic                 enq_task_ready_i,
  output ll_ht_pdata_t         deq_task_o,
  output logic                 deq_task_valid_o,
  input  logic                 deq_task_ready_i,
  input  ll_ht_result_t        enq_result_i,
  input  logic                 enq_result_valid_i,
  output logic                 enq_result_ready_o,
  input  ll_ht_result_t        deq_result_i,
  input  logic                 deq_result_valid_i,
  output logic                 deq_result_ready_o,
  output ll_ht_result_t        result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  input  logic [A_WIDTH-1:0]   enq_rd_addr_i,
  input  logic                 enq_rd_en_i,
  input  logic [A_WIDTH-1:0]   enq_wr_addr_i,
  input  ll_ram_data_t         enq_wr_data_i,
  input  logic                 enq_wr_en_i,
  input  logic [A_WIDTH-1:0]   deq_rd_addr_i,
  input  logic                 deq_rd_en_i,
  input  logic [A_WIDTH-1:0]   deq_wr_addr_i,
  input  ll_ram_data_t         deq_wr_data_i,
  input  logic                 deq_wr_en_i,
  output logic [A_WIDTH-1:0]   ram_rd_addr_o,
  output logic                 ram_rd_en_o,
  output logic [A_WIDTH-1:0]   ram_wr_addr_o,
  output ll_ram_data_t         ram_wr_data_o,
  output logic                 ram_wr_en_o,
  output logic [CNT_WIDTH-1:0] enq_cnt_o,
  output logic [CNT_WIDTH-1:0] deq_cnt_o,
  output logic                 err_o
);

  localparam logic [1:0] IDLE_S     = 2'd0;
  localparam logic [1:0] DISPATCH_S = 2'd1;
  localparam logic [1:0] WAIT_RES_S = 2'd2;
  localparam logic [1:0] RESULT_S   = 2'd3;

  logic [1:0]           state_q;
  ll_disp_owner_t       owner_q;
  ll_ht_pdata_t         task_q;
  ll_ht_result_t        result_q;
  logic [CNT_WIDTH-1:0] enq_cnt_q;
  logic [CNT_WIDTH-1:0] deq_cnt_q;
  logic                 err_q;
  logic                 violation;
  logic                 disp_fire;
  logic                 res_fire;
  ll_disp_owner_t       new_owner;

  // Gated by reset so upstream never sees ready while the block is held in reset.
  assign task_ready_o = rst_n_i & (state_q == IDLE_S);

  assign enq_task_o       = task_q;
  assign deq_task_o       = task_q;
  assign enq_task_valid_o = (state_q == DISPATCH_S) & (owner_q == OWNER_ENQ);
  assign deq_task_valid_o = (state_q == DISPATCH_S) & (owner_q == OWNER_DEQ);

  assign enq_result_ready_o = (state_q == WAIT_RES_S) & (owner_q == OWNER_ENQ);
  assign deq_result_ready_o = (state_q == WAIT_RES_S) & (owner_q == OWNER_DEQ);

  assign result_o       = result_q;
  assign result_valid_o = (state_q == RESULT_S);

  assign disp_fire = (enq_task_valid_o & enq_task_ready_i) | (deq_task_valid_o & deq_task_ready_i);
  assign res_fire  = (enq_result_valid_i & enq_result_ready_o) | (deq_result_valid_i & deq_result_ready_o);
  assign new_owner = owner_of(task_i.cmd.opcode);

  assign enq_cnt_o = enq_cnt_q;
  assign deq_cnt_o = deq_cnt_q;
  assign err_o     = err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE_S;
      owner_q   <= OWNER_NONE;
      task_q    <= '0;
      result_q  <= '0;
      enq_cnt_q <= '0;
      deq_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_q | violation;
      case (state_q)
        IDLE_S: begin
          if (task_valid_i) begin
            task_q  <= task_i;
            owner_q <= new_owner;
            if (new_owner == OWNER_NONE) begin
              result_q <= '{cmd: task_i.cmd, rescode: LL_UNKNOWN_OPCODE, chain_state: LL_NO_CHAIN};
              state_q  <= RESULT_S;
            end else begin
              state_q  <= DISPATCH_S;
            end
          end
        end
        DISPATCH_S: begin
          if (disp_fire) state_q <= WAIT_RES_S;
        end
        WAIT_RES_S: begin
          if (res_fire) begin
            result_q <= (owner_q == OWNER_DEQ) ? deq_result_i : enq_result_i;
            state_q  <= RESULT_S;
            if (owner_q == OWNER_DEQ) deq_cnt_q <= deq_cnt_q + 1'b1;
            else                      enq_cnt_q <= enq_cnt_q + 1'b1;
          end
        end
        RESULT_S: begin
          // Ownership (and RAM access) lasts until the result leaves, covering late write-backs.
          if (result_ready_i) begin
            state_q <= IDLE_S;
            owner_q <= OWNER_NONE;
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  ll_ram_port_mux #(.A_WIDTH(A_WIDTH)) u_ram_mux (
    .owner       (owner_q),
    .enq_rd_addr (enq_rd_addr_i),
    .enq_rd_en   (enq_rd_en_i),
    .enq_wr_addr (enq_wr_addr_i),
    .enq_wr_data (enq_wr_data_i),
    .enq_wr_en   (enq_wr_en_i),
    .deq_rd_addr (deq_rd_addr_i),
    .deq_rd_en   (deq_rd_en_i),
    .deq_wr_addr (deq_wr_addr_i),
    .deq_wr_data (deq_wr_data_i),
    .deq_wr_en   (deq_wr_en_i),
    .ram_rd_addr (ram_rd_addr_o),
    .ram_rd_en   (ram_rd_en_o),
    .ram_wr_addr (ram_wr_addr_o),
    .ram_wr_data (ram_wr_data_o),
    .ram_wr_en   (ram_wr_en_o),
    .violation   (violation)
  );

endmodule
